tap_ir_dr: RTL and testbench
============================

# tap_ir_dr

Downstream companion to the half TAP controller. It consumes the controller's 4-bit state code plus TDI and implements the JTAG instruction register and data registers: BYPASS, IDCODE and an 8-bit USER register. It produces TDO, a TDO enable, and a parallel USER update port. It sits between the TAP state machine and the chip-level scan pins.

## Interface
- IR_W, 3, instruction register width
- IDCODE, 32'h1000_0001, device ID value; bit 0 must be 1
- USER_W, 8, USER data register width
- GCLK  in  1  single clock, rising-edge active
- TRST_N  in  1  asynchronous, active-low reset
- state_obs  in  4  TAP state code from the controller, valid for the current cycle
- TDI  in  1  serial test data in
- user_capture  in  USER_W  parallel value loaded in Capture-DR when USER is selected
- TDO  out  1  serial test data out
- TDO_en  out  1  high while in Shift-IR or Shift-DR
- ir_out  out  IR_W  current (updated) instruction
- user_update  out  USER_W  USER register parallel output
- user_strobe  out  1  one-cycle pulse when user_update is written

## Operation
- The state encoding is fixed, in hex:
  - TLR=F, RTI=C
  - Sel-DR=7, Cap-DR=6, Shift-DR=2, Ex1-DR=1, Pause-DR=3, Ex2-DR=0, Upd-DR=5
  - Sel-IR=4, Cap-IR=E, Shift-IR=A, Ex1-IR=9, Pause-IR=B, Ex2-IR=8, Upd-IR=D
- Instructions:
  - 3'b001 = IDCODE
  - 3'b010 = USER
  - 3'b111 = BYPASS
  - Any other code selects BYPASS.
- Registers: ir_shift[IR_W], ir[IR_W], id_shift[32], byp (1 bit), user_shift[USER_W], user_update[USER_W].
- Actions below are taken at the GCLK rising edge, keyed on state_obs sampled at that edge.
- TLR: ir <= 3'b001 (IDCODE). Shift registers are not cleared.
- Cap-IR: ir_shift <= 3'b001, the mandatory ...01 pattern.
- Shift-IR: ir_shift <= {TDI, ir_shift[IR_W-1:1]} (LSB first out).
- Upd-IR: ir <= ir_shift.
- Cap-DR, depending on the selected register:
  - IDCODE: id_shift <= IDCODE
  - USER: user_shift <= user_capture
  - BYPASS: byp <= 0
- Shift-DR: the selected register shifts right with TDI entering the MSB. BYPASS: byp <= TDI.
- Upd-DR with USER selected: user_update <= user_shift and user_strobe = 1 for exactly the next cycle. No other register changes in Upd-DR.
- Pause, Exit, Select and RTI states hold all registers.
- TDO is combinational:
  - Shift-IR: ir_shift[0]
  - Shift-DR: LSB of the selected DR (byp for BYPASS)
  - Otherwise: 0
- TDO_en = (state_obs==A) | (state_obs==2).
- DR selection always uses ir, never ir_shift. A new instruction therefore takes effect only after Upd-IR.

## Timing
- Reset, asynchronous on TRST_N low:
  - ir = 3'b001; ir_shift = 0; id_shift = 0; byp = 0; user_shift = 0
  - user_update = 0; user_strobe = 0
  - TDO = 0, TDO_en = 0 (regardless of state_obs while reset is held)
- Reset deassertion is used synchronously only through the flops. The first action occurs at the first rising edge with TRST_N=1.
- Reset mid-shift discards partial shift contents. The ir update is suppressed.
- Latency:
  - The captured LSB appears on TDO combinationally as soon as state_obs enters Shift. No edge is needed.
  - Each Shift-state edge advances TDO by one bit.
- Bits out equal the number of edges spent in the Shift state. An IR_W-bit IR scan needs exactly IR_W Shift-IR edges; the last bit is shifted on the edge that leaves toward Ex1.
- BYPASS delays TDI by exactly one Shift-DR edge.
- An Upd-IR edge followed immediately by a Cap-DR edge captures using the new ir.
- user_strobe is registered:
  - It is high for the single cycle after the Upd-DR edge.
  - It never asserts for IDCODE or BYPASS.
  - It is never high on two consecutive cycles, because Upd-DR always exits to Sel-DR or RTI.
- An unknown state code (not possible with a 4-bit full encoding) does not arise. Every code is mapped above.

## Test plan
- Reset then TLR:
  - TRST_N pulse low, then state_obs=F for 3 edges -> ir_out=3'b001, TDO_en=0, user_update=8'h00.
- IDCODE read:
  - After reset, sequence C,7,6, then 32 edges in 2 -> TDO stream LSB-first equals 32'h1000_0001.
  - First bit is 1 before any shift edge. TDO_en=1 throughout.
- IR capture/load:
  - Sequence 7,4,E, then 3 edges in A with TDI=0,1,0, then 9,D -> TDO during shift is 1,0,0 and ir_out=3'b010 after the D edge.
- USER write/read:
  - ir=USER, user_capture=8'hA5, sequence 6, then 8 shifts of TDI=8'h3C LSB-first, then 1,5 -> TDO streams 8'hA5 LSB-first.
  - user_update=8'h3C. user_strobe is high exactly one cycle.
- BYPASS and illegal code:
  - Load ir=3'b100, then DR scan with TDI pattern 1,1,0,1 -> TDO is 0,1,1,0 (one-bit delay).
  - ir_out=3'b100. user_strobe stays 0.
- Async reset mid-shift:
  - TRST_N low during the 4th Shift-DR edge of a USER scan -> TDO=0, TDO_en=0 and all registers at reset values immediately.
  - No strobe fires afterwards.

Source files
------------

// File: rtl/tap_ir_dr_if.sv
// Signal bundle between the TAP controller side and the IR/DR block.
// The master drives the TAP state code and scan inputs; the slave returns TDO and the USER port.
interface tap_ir_dr_if #(
   parameter int unsigned IR_W   = 3,
   parameter int unsigned USER_W = 8
);
   logic [3:0]        state_obs;
   logic              TDI;
   logic [USER_W-1:0] user_capture;
   logic              TDO;
   logic              TDO_en;
   logic [IR_W-1:0]   ir_out;
   logic [USER_W-1:0] user_update;
   logic              user_strobe;

   modport master (
      output state_obs, TDI, user_capture,
      input  TDO, TDO_en, ir_out, user_update, user_strobe
   );

   modport slave (
      input  state_obs, TDI, user_capture,
      output TDO, TDO_en, ir_out, user_update, user_strobe
   );
endinterface

// File: rtl/tap_ir_dr.sv
// JTAG instruction register plus BYPASS, IDCODE and USER data registers,
// driven by the state code of an external TAP controller.
module tap_ir_dr #(
   parameter int unsigned IR_W   = 3,
   parameter logic [31:0] IDCODE = 32'h1000_0001,
   parameter int unsigned USER_W = 8
) (
   input logic         GCLK,
   input logic         TRST_N,
   tap_ir_dr_if.slave  bus
);
   typedef enum logic [3:0] {
      S_EX2_DR   = 4'h0, S_EX1_DR   = 4'h1, S_SHIFT_DR = 4'h2, S_PAUSE_DR = 4'h3,
      S_SEL_IR   = 4'h4, S_UPD_DR   = 4'h5, S_CAP_DR   = 4'h6, S_SEL_DR   = 4'h7,
      S_EX2_IR   = 4'h8, S_EX1_IR   = 4'h9, S_SHIFT_IR = 4'hA, S_PAUSE_IR = 4'hB,
      S_RTI      = 4'hC, S_UPD_IR   = 4'hD, S_CAP_IR   = 4'hE, S_TLR      = 4'hF
   } tap_state_e;

   typedef enum logic [1:0] {DR_BYPASS, DR_IDCODE, DR_USER} dr_sel_e;

   localparam logic [IR_W-1:0] INSTR_IDCODE = IR_W'(1);
   localparam logic [IR_W-1:0] INSTR_USER   = IR_W'(2);
   // Cap-IR loads the mandatory ...01 pattern, which happens to equal the IDCODE opcode.
   localparam logic [IR_W-1:0] IR_CAPTURE   = IR_W'(1);

   tap_state_e        state;
   dr_sel_e           dr_sel;

   logic [IR_W-1:0]   ir_q, ir_d;
   logic [IR_W-1:0]   ir_shift_q, ir_shift_d;
   logic [31:0]       id_shift_q, id_shift_d;
   logic              byp_q, byp_d;
   logic [USER_W-1:0] user_shift_q, user_shift_d;
   logic [USER_W-1:0] user_update_q, user_update_d;
   logic              user_strobe_q, user_strobe_d;
   logic              tdo;

   assign state = tap_state_e'(bus.state_obs);

   // DR selection follows the updated instruction only, never the IR shift stage.
   always_comb begin
      case (ir_q)
         INSTR_IDCODE: dr_sel = DR_IDCODE;
         INSTR_USER:   dr_sel = DR_USER;
         default:      dr_sel = DR_BYPASS;
      endcase
   end

   always_comb begin
      // NOTE: every next-state signal defaults to its hold value first, so no path can infer a latch.
      ir_d          = ir_q;
      ir_shift_d    = ir_shift_q;
      id_shift_d    = id_shift_q;
      byp_d         = byp_q;
      user_shift_d  = user_shift_q;
      user_update_d = user_update_q;
      user_strobe_d = 1'b0;
      case (state)
         S_TLR:      ir_d = INSTR_IDCODE;
         S_CAP_IR:   ir_shift_d = IR_CAPTURE;
         S_SHIFT_IR: ir_shift_d = {bus.TDI, ir_shift_q[IR_W-1:1]};
         S_UPD_IR:   ir_d = ir_shift_q;
         S_CAP_DR: begin
            case (dr_sel)
               DR_IDCODE: id_shift_d   = IDCODE;
               DR_USER:   user_shift_d = bus.user_capture;
               default:   byp_d        = 1'b0;
            endcase
         end
         S_SHIFT_DR: begin
            case (dr_sel)
               DR_IDCODE: id_shift_d   = {bus.TDI, id_shift_q[31:1]};
               DR_USER:   user_shift_d = {bus.TDI, user_shift_q[USER_W-1:1]};
               default:   byp_d        = bus.TDI;
            endcase
         end
         S_UPD_DR: begin
            if (dr_sel == DR_USER) begin
               user_update_d = user_shift_q;
               user_strobe_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge GCLK or negedge TRST_N) begin
      if (!TRST_N) begin
         ir_q          <= INSTR_IDCODE;
         ir_shift_q    <= '0;
         id_shift_q    <= '0;
         byp_q         <= 1'b0;
         user_shift_q  <= '0;
         user_update_q <= '0;
         user_strobe_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments here so every flop samples pre-edge values.
         ir_q          <= ir_d;
         ir_shift_q    <= ir_shift_d;
         id_shift_q    <= id_shift_d;
         byp_q         <= byp_d;
         user_shift_q  <= user_shift_d;
         user_update_q <= user_update_d;
         user_strobe_q <= user_strobe_d;
      end
   end

   // TDO is combinational so the captured LSB is visible on Shift entry without an edge.
   always_comb begin
      tdo = 1'b0;
      if (state == S_SHIFT_IR) begin
         tdo = ir_shift_q[0];
      end else if (state == S_SHIFT_DR) begin
         case (dr_sel)
            DR_IDCODE: tdo = id_shift_q[0];
            DR_USER:   tdo = user_shift_q[0];
            default:   tdo = byp_q;
         endcase
      end
   end

   assign bus.TDO         = TRST_N & tdo;
   assign bus.TDO_en      = TRST_N & ((state == S_SHIFT_IR) | (state == S_SHIFT_DR));
   assign bus.ir_out      = ir_q;
   assign bus.user_update = user_update_q;
   assign bus.user_strobe = user_strobe_q;
endmodule

// File: tb/tb_tap_ir_dr.sv
// Bench for tap_ir_dr: queue-based scan-chain model checked every cycle, directed
// scans with literal expectations, then a random walk through the TAP state graph.
module tb_tap_ir_dr;
   localparam int IR_W   = 3;
   localparam int USER_W = 8;
   localparam logic [31:0] IDC = 32'h1000_0001;

   logic gclk   = 1'b0;
   logic trst_n = 1'b1;
   int   n_vec  = 0;
   int   n_fail = 0;
   int   strobe_cnt;
   logic last_tdo;

   tap_ir_dr_if #(.IR_W(IR_W), .USER_W(USER_W)) bus ();

   tap_ir_dr #(.IR_W(IR_W), .IDCODE(IDC), .USER_W(USER_W)) dut (
      .GCLK   (gclk),
      .TRST_N (trst_n),
      .bus    (bus.slave)
   );

   always #5 gclk = ~gclk;

   // Model: each scan chain is a bit queue, front = bit presented on TDO.
   bit         ir_bits[$];
   bit         id_bits[$];
   bit         user_bits[$];
   bit         m_byp;
   int         m_ir;
   int         m_upd;
   bit         m_strobe;

   function automatic int q2int(input bit q[$]);
      int v = 0;
      foreach (q[i]) v = v | (int'(q[i]) << i);
      return v;
   endfunction

   task automatic model_reset();
      ir_bits = {}; id_bits = {}; user_bits = {};
      for (int i = 0; i < IR_W; i++) ir_bits.push_back(1'b0);
      for (int i = 0; i < 32; i++) id_bits.push_back(1'b0);
      for (int i = 0; i < USER_W; i++) user_bits.push_back(1'b0);
      m_byp = 1'b0; m_ir = 1; m_upd = 0; m_strobe = 1'b0;
   endtask

   always @(posedge gclk or negedge trst_n) begin
      if (!trst_n) begin
         model_reset();
      end else begin
         m_strobe = 1'b0;
         case (bus.state_obs)
            4'hF: m_ir = 1;
            4'hE: begin
               ir_bits = {};
               ir_bits.push_back(1'b1);
               for (int i = 1; i < IR_W; i++) ir_bits.push_back(1'b0);
            end
            4'hA: begin
               void'(ir_bits.pop_front());
               ir_bits.push_back(bus.TDI);
            end
            4'hD: m_ir = q2int(ir_bits);
            4'h6: begin
               if (m_ir == 1) begin
                  id_bits = {};
                  for (int i = 0; i < 32; i++) id_bits.push_back(IDC[i]);
               end else if (m_ir == 2) begin
                  user_bits = {};
                  for (int i = 0; i < USER_W; i++) user_bits.push_back(bus.user_capture[i]);
               end else begin
                  m_byp = 1'b0;
               end
            end
            4'h2: begin
               if (m_ir == 1) begin
                  void'(id_bits.pop_front()); id_bits.push_back(bus.TDI);
               end else if (m_ir == 2) begin
                  void'(user_bits.pop_front()); user_bits.push_back(bus.TDI);
               end else begin
                  m_byp = bus.TDI;
               end
            end
            4'h5: if (m_ir == 2) begin
               m_upd = q2int(user_bits);
               m_strobe = 1'b1;
            end
            default: ;
         endcase
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_all();
      logic e_tdo;
      logic e_en;
      e_tdo = 1'b0;
      if (trst_n) begin
         if (bus.state_obs == 4'hA) e_tdo = ir_bits[0];
         else if (bus.state_obs == 4'h2)
            e_tdo = (m_ir == 1) ? id_bits[0] : (m_ir == 2) ? user_bits[0] : m_byp;
      end
      e_en = trst_n && (bus.state_obs == 4'hA || bus.state_obs == 4'h2);
      check("tdo", 32'(bus.TDO), 32'(e_tdo));
      check("tdo_en", 32'(bus.TDO_en), 32'(e_en));
      check("ir_out", 32'(bus.ir_out), 32'(m_ir));
      check("user_update", 32'(bus.user_update), 32'(m_upd));
      check("user_strobe", 32'(bus.user_strobe), 32'(m_strobe));
   endtask

   // One clock cycle in state st; inputs change #1 after the rising edge.
   task automatic step(input logic [3:0] st, input logic tdi);
      bus.state_obs = st;
      bus.TDI = tdi;
      @(negedge gclk);
      compare_all();
      last_tdo = bus.TDO;
      if (bus.user_strobe) strobe_cnt++;
      @(posedge gclk);
      #1;
   endtask

   task automatic ir_scan(input logic [IR_W-1:0] val, output logic [IR_W-1:0] rx);
      step(4'h7, 1'b0); step(4'h4, 1'b0); step(4'hE, 1'b0);
      for (int i = 0; i < IR_W; i++) begin
         step(4'hA, val[i]);
         rx[i] = last_tdo;
      end
      step(4'h9, 1'b0); step(4'hD, 1'b0);
   endtask

   function automatic logic [3:0] tap_next(input logic [3:0] s, input bit tms);
      case (s)
         4'hF: return tms ? 4'hF : 4'hC;
         4'hC: return tms ? 4'h7 : 4'hC;
         4'h7: return tms ? 4'h4 : 4'h6;
         4'h6: return tms ? 4'h1 : 4'h2;
         4'h2: return tms ? 4'h1 : 4'h2;
         4'h1: return tms ? 4'h5 : 4'h3;
         4'h3: return tms ? 4'h0 : 4'h3;
         4'h0: return tms ? 4'h5 : 4'h2;
         4'h5: return tms ? 4'h7 : 4'hC;
         4'h4: return tms ? 4'hF : 4'hE;
         4'hE: return tms ? 4'h9 : 4'hA;
         4'hA: return tms ? 4'h9 : 4'hA;
         4'h9: return tms ? 4'hD : 4'hB;
         4'hB: return tms ? 4'h8 : 4'hB;
         4'h8: return tms ? 4'hD : 4'hA;
         default: return tms ? 4'h7 : 4'hC;
      endcase
   endfunction

   initial begin
      logic [31:0]       id_rx;
      logic [IR_W-1:0]   ir_rx;
      logic [USER_W-1:0] user_rx;
      logic [3:0]        byp_rx;
      logic [3:0]        cur;
      logic [7:0]        user_tdi;
      logic [3:0]        byp_tdi;

      bus.state_obs = 4'hF; bus.TDI = 1'b0; bus.user_capture = '0;
      strobe_cnt = 0;
      #2 trst_n = 1'b0;
      #1;
      check("rst_tdo", 32'(bus.TDO), 32'd0);
      check("rst_tdo_en", 32'(bus.TDO_en), 32'd0);
      @(posedge gclk); #1;
      trst_n = 1'b1;

      // Reset then TLR
      repeat (3) step(4'hF, 1'b0);
      check("tlr_ir", 32'(bus.ir_out), 32'd1);
      check("tlr_upd", 32'(bus.user_update), 32'h00);

      // IDCODE read, LSB first
      step(4'hC, 1'b0); step(4'h7, 1'b0); step(4'h6, 1'b0);
      for (int i = 0; i < 32; i++) begin
         step(4'h2, 1'b0);
         id_rx[i] = last_tdo;
         if (i == 0) check("id_first_en", 32'(bus.TDO_en), 32'd1);
      end
      check("idcode_stream", id_rx, 32'h1000_0001);
      step(4'h1, 1'b0); step(4'h5, 1'b0); step(4'hC, 1'b0);

      // IR capture/load USER
      ir_scan(3'b010, ir_rx);
      check("ir_capture_stream", 32'(ir_rx), 32'b001);
      check("ir_loaded_user", 32'(bus.ir_out), 32'b010);
      step(4'hC, 1'b0);

      // USER write/read
      bus.user_capture = 8'hA5;
      user_tdi = 8'h3C;
      strobe_cnt = 0;
      step(4'h7, 1'b0); step(4'h6, 1'b0);
      for (int i = 0; i < USER_W; i++) begin
         step(4'h2, user_tdi[i]);
         user_rx[i] = last_tdo;
      end
      step(4'h1, 1'b0); step(4'h5, 1'b0); step(4'hC, 1'b0); step(4'hC, 1'b0);
      check("user_stream", 32'(user_rx), 32'hA5);
      check("user_update_val", 32'(bus.user_update), 32'h3C);
      check("user_strobe_cnt", 32'(strobe_cnt), 32'd1);

      // BYPASS via illegal code 3'b100
      strobe_cnt = 0;
      ir_scan(3'b100, ir_rx);
      byp_tdi = 4'b1011;  // TDI order 1,1,0,1 (bit 0 first)
      step(4'h7, 1'b0); step(4'h6, 1'b0);
      for (int i = 0; i < 4; i++) begin
         step(4'h2, byp_tdi[i]);
         byp_rx[i] = last_tdo;
      end
      step(4'h1, 1'b0); step(4'h5, 1'b0); step(4'hC, 1'b0);
      check("bypass_stream", 32'(byp_rx), 32'b0110);
      check("bypass_ir", 32'(bus.ir_out), 32'b100);
      check("bypass_no_strobe", 32'(strobe_cnt), 32'd0);

      // Async reset during the 4th Shift-DR edge of a USER scan
      ir_scan(3'b010, ir_rx);
      step(4'hC, 1'b0);
      bus.user_capture = 8'h5A;
      step(4'h7, 1'b0); step(4'h6, 1'b0);
      repeat (3) step(4'h2, 1'b1);
      bus.state_obs = 4'h2;
      @(negedge gclk);
      compare_all();
      #2 trst_n = 1'b0;
      #1;
      check("mid_rst_tdo", 32'(bus.TDO), 32'd0);
      check("mid_rst_en", 32'(bus.TDO_en), 32'd0);
      check("mid_rst_ir", 32'(bus.ir_out), 32'd1);
      check("mid_rst_upd", 32'(bus.user_update), 32'd0);
      check("mid_rst_strobe", 32'(bus.user_strobe), 32'd0);
      @(posedge gclk); #1;
      strobe_cnt = 0;
      repeat (2) step(4'h2, 1'b1);
      trst_n = 1'b1;
      step(4'h2, 1'b1); step(4'h1, 1'b0); step(4'h5, 1'b0);
      step(4'hC, 1'b0); step(4'hC, 1'b0);
      check("post_rst_no_strobe", 32'(strobe_cnt), 32'd0);
      check("post_rst_ir", 32'(bus.ir_out), 32'd1);

      // Random walk through the TAP graph
      cur = 4'hF;
      for (int n = 0; n < 1500; n++) begin
         bus.user_capture = USER_W'($urandom);
         step(cur, 1'($urandom));
         cur = tap_next(cur, ($urandom_range(0, 3) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule
